// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: WIDTH-bit add/subtract sequenced through one shared SLICE-bit adder slice,
// with the slice carry registered between passes and valid/ready on both sides.
module add_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [SLICE:0]   sum;
    logic             last;
    assign sum  = {1'b0, a_r[k*SLICE +: SLICE]} + {1'b0, b_r[k*SLICE +: SLICE]} + {{SLICE{1'b0}}, carry};
    assign last = k == KW'(N - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r      <= a;
                    b_r      <= sub ? ~b : b;
                    carry    <= sub ? 1'b1 : c_in;
                    k        <= '0;
                    in_ready <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    s[k*SLICE +: SLICE] <= sum[SLICE-1:0];
                    carry               <= sum[SLICE];
                    k                   <= last ? k : k + 1'b1;
                    if (last) begin
                        // the MSB slice sum is the final s[MSB]
                        c_out     <= sum[SLICE];
                        ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[SLICE-1] != a_r[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: randomized and directed checks of add_seq_ctrl against a full-width arithmetic model.
module tb_add_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] s;
    logic        c_out;
    logic        ovf;
    int          checks = 0;
    int          failures = 0;

    add_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // hold: cycles of out_ready=0 in DONE; keep_req: present junk requests while busy and leave in_valid high
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tsub, input logic tcin,
                          input int hold, input logic keep_req);
        logic [32:0] full;
        logic [31:0] be;
        logic        eo;
        int          n;
        be   = tsub ? ~tb2 : tb2;
        full = {1'b0, ta} + {1'b0, be} + {32'd0, tsub ? 1'b1 : tcin};
        eo   = (ta[31] == be[31]) && (full[31] != ta[31]);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_accept", 64'(in_ready), 64'(1));
        a = ta; b = tb2; sub = tsub; c_in = tcin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = keep_req;
        a = $urandom; b = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
        out_ready = 1'($urandom);
        chk("busy_after_accept", 64'(in_ready), 64'(0));
        chk("no_valid_at_accept", 64'(out_valid), 64'(0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("early_valid", 64'(out_valid), 64'(0));
            out_ready = 1'($urandom);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("valid_at_T0+4", 64'(out_valid), 64'(1));
        chk("sum", 64'(s), 64'(full[31:0]));
        chk("c_out", 64'(c_out), 64'(full[32]));
        chk("ovf", 64'(ovf), 64'(eo));
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_ready", 64'(in_ready), 64'(0));
            chk("hold_s", {31'd0, c_out, ovf, s}, {31'd0, full[32], eo, full[31:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("released_valid", 64'(out_valid), 64'(0));
        chk("released_ready", 64'(in_ready), 64'(1));
        chk("s_kept_idle", 64'(s), 64'(full[31:0]));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_outputs", {31'd0, c_out, ovf, s}, 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'd5, 32'd7, 1'b1, 1'b1, 1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'h00FF_FFFF, 32'h0, 1'b0, 1'b1, 0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0);
        // backpressure with a second request held high throughout
        run_op($urandom, $urandom, 1'b0, 1'b1, 3, 1'b1);
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        in_valid = 1'b0;
        // reset during RUN at k=2
        @(posedge clk); #1;
        a = $urandom; b = $urandom; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_s", 64'(s), 64'(0));
        chk("async_rst_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_pulse_after_rst", 64'(out_valid), 64'(0));
        end
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0);
        chk("post_rst_sum", 64'(s), 64'(7));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
